// File: rtl/imem_fetch_controller_pkg.sv
// Shared types for the instruction fetch path: FSM states, FIFO entry layout, address helpers.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam int unsigned WORD_BYTES       = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fifo_entry_t;

   // First byte address past the end of a memory of mem_words words.
   function automatic logic [31:0] pc_limit(input int unsigned mem_words);
      return 32'(mem_words * WORD_BYTES);
   endfunction

endpackage

// File: rtl/imem_fetch_controller_if.sv
// Fetch controller bus: memory address/data pair, redirect input and decode-side valid/ready.
interface imem_fetch_controller_if;

   logic        fetch_en;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fault;

   modport master (
      input  fetch_en,
      input  imem_instr,
      input  redirect_valid,
      input  redirect_pc,
      input  instr_ready,
      output imem_pc,
      output instr_valid,
      output instr,
      output instr_pc,
      output fault
   );

   modport slave (
      output fetch_en,
      output imem_instr,
      output redirect_valid,
      output redirect_pc,
      output instr_ready,
      input  imem_pc,
      input  instr_valid,
      input  instr,
      input  instr_pc,
      input  fault
   );

endinterface

// File: rtl/imem_fetch_controller_fifo.sv
// Generic synchronous FIFO of fetch entries; head visible same cycle, no fall-through.
// Flush beats push; a push into a full FIFO is accepted only alongside a pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CW    = $clog2(DEPTH + 1),
   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  fifo_entry_t   push_dat,
   input  logic          pop,
   output fifo_entry_t   head,
   output logic [CW-1:0] count
);

   fifo_entry_t   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_ok;
   logic          push_ok;
   logic          wr_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop_ok  = pop && (count_q != '0);
   assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);
   assign wr_en   = push_ok && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset: contents are only observable while count is non-zero.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/imem_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives a 1-cycle-latency memory, buffers words for decode.
// Issue-to-valid is 2 cycles; issue stalls so buffered plus in-flight words never exceed FIFO_DEPTH.
module imem_fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned MEM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input logic                      clk,
   input logic                      reset,
   imem_fetch_controller_if.master  bus
);

   localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] PC_LIMIT = pc_limit(MEM_WORDS);

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic          inflight_q, inflight_d;

   logic [CW-1:0] fifo_count;
   fifo_entry_t   fifo_head;
   fifo_entry_t   push_dat;
   logic          instr_valid_w;
   logic          pop;
   logic          fetching;
   logic          redirect_take;
   logic          redirect_flush;
   logic          redirect_bad;
   logic          pc_bad;
   logic          drained;
   logic          room;
   logic          range_fault;
   logic          fault_now;
   logic          issue;
   logic          flush;

   assign instr_valid_w  = (fifo_count != '0) && (state_q != FAULT);
   assign pop            = instr_valid_w && bus.instr_ready;
   assign fetching       = (state_q == FETCH) && bus.fetch_en;

   assign redirect_take  = bus.redirect_valid && (state_q != FAULT);
   assign redirect_flush = bus.redirect_valid && (state_q == FETCH);
   assign redirect_bad   = redirect_take && (bus.redirect_pc[1:0] != 2'b00);

   assign pc_bad  = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);
   assign drained = (fifo_count == '0) && !inflight_q;
   assign room    = (32'(fifo_count) + 32'(inflight_q)) < (FIFO_DEPTH + 32'(pop));

   // An illegal PC only faults once every older word has reached decode.
   assign range_fault = fetching && !bus.redirect_valid && pc_bad && drained;
   assign fault_now   = redirect_bad || range_fault;
   assign issue       = fetching && !bus.redirect_valid && !pc_bad && room;
   assign flush       = redirect_flush || fault_now;

   assign push_dat.instr = bus.imem_instr;
   assign push_dat.pc    = inflight_pc_q;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .push     (inflight_q),
      .push_dat (push_dat),
      .pop      (pop),
      .head     (fifo_head),
      .count    (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.fetch_en)  state_d = FETCH;
         FETCH:   if (!bus.fetch_en) state_d = IDLE;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
      if (fault_now) begin
         state_d = FAULT;
      end
   end

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (redirect_take && !redirect_bad) begin
         pc_d = bus.redirect_pc;
      end else if (issue) begin
         pc_d = pc_q + 32'(WORD_BYTES);
      end
      if (issue) begin
         inflight_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   assign bus.imem_pc     = pc_q;
   assign bus.instr_valid = instr_valid_w;
   assign bus.instr       = instr_valid_w ? fifo_head.instr : '0;
   assign bus.instr_pc    = instr_valid_w ? fifo_head.pc : '0;
   assign bus.fault       = (state_q == FAULT);

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Randomized scoreboard bench: expected word stream is rebuilt at every reset/redirect, a monitor checks each transfer.
module tb_imem_fetch_controller;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int          MEM_WORDS  = 64;
   localparam int          FIFO_DEPTH = 2;
   localparam logic [31:0] LIMIT      = 32'(MEM_WORDS * 4);

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   imem_fetch_controller_if bus ();

   imem_fetch_controller #(
      .RESET_PC   (RESET_PC),
      .MEM_WORDS  (MEM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [MEM_WORDS];
   exp_t        exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;

   logic        pend_reset   = 1'b1;
   logic        pend_redir   = 1'b0;
   logic [31:0] pend_pc      = '0;
   logic        model_fetch  = 1'b0;
   logic        expect_fault = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every legal word from start to the end of memory, in address order.
   task automatic push_stream(input logic [31:0] start);
      for (int a = int'(start); a < MEM_WORDS * 4; a += 4) begin
         exp_q.push_back('{pc: 32'(a), instr: mem[a / 4]});
      end
   endtask

   // One clock of stimulus; reset/redirect effects reach the model a cycle later so
   // a transfer completing in the redirect cycle is still matched against the old stream.
   task automatic cycle(input logic rst, input logic fe, input logic rdy,
                        input logic rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      expect_fault = 1'b0;
      if (pend_reset) begin
         exp_q.delete();
         push_stream(RESET_PC);
      end else if (pend_redir) begin
         exp_q.delete();
         if (pend_pc[1:0] == 2'b00) push_stream(pend_pc);
         else expect_fault = 1'b1;
      end
      pend_reset  = rst;
      pend_redir  = rv && (model_fetch || (rpc[1:0] != 2'b00));
      pend_pc     = rpc;
      model_fetch = fe && !rst;
      reset              = rst;
      bus.fetch_en       = fe;
      bus.instr_ready    = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
   endtask

   task automatic run(input int n, input logic fe, input logic rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, fe, rdy, 1'b0, 32'h0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'h0);
      chk({tag, "_instr"},       bus.instr,             32'h0);
      chk({tag, "_instr_pc"},    bus.instr_pc,          32'h0);
      chk({tag, "_fault"},       32'(bus.fault),        32'h0);
      chk({tag, "_imem_pc"},     bus.imem_pc,           RESET_PC);
   endtask

   // Memory model: address seen during cycle C, data valid from just after the edge ending C.
   initial begin
      logic [31:0] a;
      bus.imem_instr = '0;
      forever begin
         @(negedge clk);
         a = bus.imem_pc;
         @(posedge clk);
         #1;
         bus.imem_instr = (a < LIMIT) ? mem[int'(a >> 2)] : 32'hDEAD_BEEF;
      end
   end

   // Monitor: every completed transfer must be the next expected word.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_word: got pc %h, no word expected", bus.instr_pc);
            end else begin
               e = exp_q.pop_front();
               chk("instr_pc", bus.instr_pc, e.pc);
               chk("instr", bus.instr, e.instr);
            end
         end
      end
   end

   initial begin
      logic [31:0] saved;
      logic        rst, fe, rdy, rv;
      logic [31:0] rpc;

      for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
      bus.fetch_en       = 1'b0;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

      // Streaming from reset: one address per cycle, first valid two cycles after first issue.
      for (int k = 0; k < 9; k++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         @(negedge clk);
         if (k == 0) begin
            chk_reset_state("reset");
         end else begin
            chk("stream_imem_pc", bus.imem_pc, RESET_PC + 32'(4 * (k - 1)));
            chk("stream_valid", 32'(bus.instr_valid), 32'(k >= 3));
         end
      end

      // Redirect mid-stream: stale words dropped, new target valid three cycles later.
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h20);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("redir_r1_valid", 32'(bus.instr_valid), 32'h0);
      chk("redir_r1_imem_pc", bus.imem_pc, 32'h20);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("redir_r2_valid", 32'(bus.instr_valid), 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("redir_r3_valid", 32'(bus.instr_valid), 32'h1);
      chk("redir_r3_pc", bus.instr_pc, 32'h20);

      // Backpressure: issue stops once the buffer is full, then drains in order.
      run(4, 1'b1, 1'b0);
      @(negedge clk);
      saved = bus.imem_pc;
      run(2, 1'b1, 1'b0);
      @(negedge clk);
      chk("stall_imem_pc_frozen", bus.imem_pc, saved);
      chk("stall_valid_held", 32'(bus.instr_valid), 32'h1);
      run(8, 1'b1, 1'b1);

      // fetch_en low: outstanding word still delivered, pc holds.
      run(2, 1'b0, 1'b1);
      @(negedge clk);
      saved = bus.imem_pc;
      run(1, 1'b0, 1'b1);
      @(negedge clk);
      chk("idle_imem_pc_frozen", bus.imem_pc, saved);
      run(4, 1'b1, 1'b1);

      // Reset mid-stream.
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk_reset_state("midreset");
      run(8, 1'b1, 1'b1);

      // Misaligned redirect: sticky fault until reset.
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h22);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("misalign_fault", 32'(bus.fault), 32'h1);
      chk("misalign_valid", 32'(bus.instr_valid), 32'h0);
      saved = bus.imem_pc;
      run(5, 1'b1, 1'b1);
      @(negedge clk);
      chk("misalign_pc_held", bus.imem_pc, saved);
      chk("misalign_fault_sticky", 32'(bus.fault), 32'h1);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("fault_cleared", 32'(bus.fault), 32'h0);

      // Run off the end of memory: last words delivered, then fault.
      run(5, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hF0);
      run(15, 1'b1, 1'b1);
      @(negedge clk);
      chk("range_fault", 32'(bus.fault), 32'h1);
      chk("range_words_left", 32'(exp_q.size()), 32'h0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 249) == 0);
         fe  = ($urandom_range(0, 7) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         rv  = !rst && model_fetch && ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 15) == 0) rpc = 32'($urandom_range(0, 255)) | 32'h1;
         else rpc = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
         cycle(rst, fe, rdy, rv, rpc);
         @(negedge clk);
         if (expect_fault) begin
            chk("rand_misalign_fault", 32'(bus.fault), 32'h1);
            chk("rand_misalign_valid", 32'(bus.instr_valid), 32'h0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
